// File: rtl/acc_decoder_if.sv
// ---------------------------------------------------------------------------
// acc_decoder_if
// Bundles the sample-input and operand-output handshakes of acc_decoder.
//
// Signals:
//   in_valid / in_ready : sample handshake (sum_in, op, ovf_in qualify it)
//   sum_in   [WIDTH]    : running-sum sample from an add/sub accumulator
//   op                  : 0 = add, 1 = subtract produced sum_in
//   ovf_in              : accumulator signed-overflow flag for sum_in
//   restart             : single-cycle request to leave HALT
//   out_valid/out_ready : operand handshake
//   d_out    [WIDTH]    : recovered operand at FIFO head
//   halted              : high while in HALT
//   count               : FIFO occupancy
//
// Handshake rule (both directions): a transfer happens on a rising clk edge
// where valid and ready are both 1. The sender keeps its payload stable while
// valid is 1 and ready is 0; ready never depends combinationally on valid.
//
// Modports: master = sample producer / operand consumer, slave = decoder.
// ---------------------------------------------------------------------------
interface acc_decoder_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum_in;
    logic             op;
    logic             ovf_in;
    logic             restart;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d_out;
    logic             halted;
    logic [CW-1:0]    count;

    modport master (
        output in_valid, sum_in, op, ovf_in, restart, out_ready,
        input  in_ready, out_valid, d_out, halted, count
    );

    modport slave (
        input  in_valid, sum_in, op, ovf_in, restart, out_ready,
        output in_ready, out_valid, d_out, halted, count
    );
endinterface

// File: rtl/acc_decoder.sv
// ---------------------------------------------------------------------------
// acc_decoder
// Recovers the operands fed to an add/sub accumulator from its running-sum
// samples (d = sum - prev for add, prev - sum for subtract, modulo 2^WIDTH)
// and queues them in a DEPTH-entry FIFO. An overflowing sample is still
// decoded and queued, then the block halts input until restart.
//
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   bus      : acc_decoder_if.slave (sample in, operand out, status)
//   state_o  : debug view of the IDLE/RUN/HALT state register
// ---------------------------------------------------------------------------
module acc_decoder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    acc_decoder_if.slave  bus,
    output logic [1:0]    state_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             in_ready_w;
    logic             out_valid_w;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] diff;

    // Ready depends only on registered state (plus rst so nothing is taken
    // during the reset cycle); the consumer's out_ready never reaches it, so a
    // pop from a full FIFO frees the slot one cycle later.
    assign in_ready_w  = !rst && (count_q != FULL) && (state_q != HALT);
    assign out_valid_w = (count_q != '0);
    assign push        = bus.in_valid && in_ready_w;
    assign pop         = out_valid_w && bus.out_ready;

    assign diff = bus.op ? (prev_q - bus.sum_in) : (bus.sum_in - prev_q);

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        unique case (state_q)
            IDLE: if (push) state_d = bus.ovf_in ? HALT : RUN;
            RUN:  if (push && bus.ovf_in) state_d = HALT;
            HALT: if (bus.restart) begin
                state_d = IDLE;
                prev_d  = '0;
            end
            default: state_d = IDLE;
        endcase
        // No push can occur in HALT, so this never collides with the clear.
        if (push) prev_d = bus.sum_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            prev_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= diff;
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.d_out     = out_valid_w ? mem_q[rd_ptr_q] : '0;
    assign bus.halted    = (state_q == HALT);
    assign bus.count     = count_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_acc_decoder.sv
// ---------------------------------------------------------------------------
// tb_acc_decoder
// Directed scenarios followed by random traffic, checked against a
// queue-based model of the decoder (operand queue, last sample, halt flag).
// ---------------------------------------------------------------------------
module tb_acc_decoder;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state_dbg;

    acc_decoder_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    acc_decoder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_dbg)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_prev = '0;
    logic             m_halt = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, compare outputs with the model,
    // advance model at the posedge, return at the next negedge.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] s, input logic o,
                         input logic ovf, input logic rs, input logic ordy,
                         input logic r);
        logic             exp_ready;
        logic             acc;
        logic             pp;
        logic [WIDTH-1:0] d;
        bus.in_valid  = v;
        bus.sum_in    = s;
        bus.op        = o;
        bus.ovf_in    = ovf;
        bus.restart   = rs;
        bus.out_ready = ordy;
        rst           = r;
        #1;
        exp_ready = (exp_q.size() < DEPTH) && !m_halt && !r;
        chk("in_ready",  {31'b0, bus.in_ready},  {31'b0, exp_ready});
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_q.size() != 0});
        chk("count",     {29'b0, bus.count},     exp_q.size());
        chk("halted",    {31'b0, bus.halted},    {31'b0, m_halt});
        if (exp_q.size() != 0) chk("d_out_head", {24'b0, bus.d_out}, {24'b0, exp_q[0]});
        acc = v && exp_ready;
        pp  = (exp_q.size() != 0) && ordy;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            m_prev = '0;
            m_halt = 1'b0;
        end else begin
            if (pp) void'(exp_q.pop_front());
            if (acc) begin
                d = o ? (m_prev - s) : (s - m_prev);
                exp_q.push_back(d);
                m_prev = s;
                if (ovf) m_halt = 1'b1;
            end else if (m_halt && rs) begin
                m_halt = 1'b0;
                m_prev = '0;
            end
        end
        @(negedge clk);
    endtask

    task automatic push(input logic [WIDTH-1:0] s, input logic o, input logic ordy);
        cycle(1'b1, s, o, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.sum_in    = '0;
        bus.op        = 1'b0;
        bus.ovf_in    = 1'b0;
        bus.restart   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  {31'b0, bus.in_ready},  32'd0);
        chk("rst_count",     {29'b0, bus.count},     32'd0);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_halted",    {31'b0, bus.halted},    32'd0);
        chk("rst_d_out",     {24'b0, bus.d_out},     32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // Basic add decoding, one-cycle latency
        push(8'h05, 1'b0, 1'b1);
        chk("seq_d0", {24'b0, bus.d_out}, 32'h05);
        push(8'h08, 1'b0, 1'b1);
        chk("seq_d1", {24'b0, bus.d_out}, 32'h03);
        push(8'h10, 1'b0, 1'b1);
        chk("seq_d2", {24'b0, bus.d_out}, 32'h08);

        // Subtract and wrap-around
        push(8'h0C, 1'b1, 1'b1);
        chk("sub_d", {24'b0, bus.d_out}, 32'h04);
        push(8'hFE, 1'b0, 1'b1);
        chk("wrap_d", {24'b0, bus.d_out}, 32'hF2);

        // Overflow -> HALT, restart -> IDLE
        push(8'h7F, 1'b0, 1'b1);
        chk("pre_ovf_d", {24'b0, bus.d_out}, 32'h81);
        cycle(1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("ovf_d",        {24'b0, bus.d_out},    32'h01);
        chk("ovf_halted",   {31'b0, bus.halted},   32'd1);
        chk("ovf_in_ready", {31'b0, bus.in_ready}, 32'd0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("restart_halted", {31'b0, bus.halted}, 32'd0);
        push(8'h03, 1'b0, 1'b1);
        chk("restart_d", {24'b0, bus.d_out}, 32'h03);
        idle(1'b1);
        idle(1'b1);

        // Full FIFO backpressure
        push(8'h11, 1'b0, 1'b0);
        push(8'h22, 1'b0, 1'b0);
        push(8'h33, 1'b0, 1'b0);
        push(8'h44, 1'b0, 1'b0);
        chk("full_count",    {29'b0, bus.count},    32'd4);
        chk("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("full_head",     {24'b0, bus.d_out},    32'h0E);
        push(8'h55, 1'b0, 1'b0);       // held
        push(8'h55, 1'b0, 1'b1);       // pop, still not accepted
        chk("after_pop_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("after_pop_head",     {24'b0, bus.d_out},    32'h11);
        push(8'h55, 1'b0, 1'b1);       // now accepted
        repeat (5) idle(1'b1);

        // Simultaneous push and pop at count 2
        push(8'h50, 1'b0, 1'b0);
        push(8'h60, 1'b0, 1'b0);
        chk("pp_count_before", {29'b0, bus.count}, 32'd2);
        chk("pp_head_before",  {24'b0, bus.d_out}, 32'hFB);
        push(8'h70, 1'b0, 1'b1);
        chk("pp_count_after", {29'b0, bus.count}, 32'd2);
        chk("pp_head_after",  {24'b0, bus.d_out}, 32'h10);
        repeat (3) idle(1'b1);

        // Reset mid-operation
        push(8'h01, 1'b0, 1'b0);
        push(8'h02, 1'b0, 1'b0);
        push(8'h03, 1'b0, 1'b0);
        chk("mid_count", {29'b0, bus.count}, 32'd3);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("mid_rst_count",     {29'b0, bus.count},     32'd0);
        chk("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("mid_rst_halted",    {31'b0, bus.halted},    32'd0);
        push(8'h09, 1'b0, 1'b1);
        chk("mid_rst_d", {24'b0, bus.d_out}, 32'h09);
        idle(1'b1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 1)),
                  WIDTH'($urandom),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 99) == 0));
        end
        repeat (6) idle(1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
